// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, also used by the capture side.
package vga_pkg;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;

   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
   localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

   localparam int VGA_IMG_W = 320;
   localparam int VGA_IMG_H = 240;

   // Each stored pixel covers a 2x2 block on screen.
   localparam int PIX_REP = 2;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic visible;
      logic image;
      logic first;
   } tmg_flags_t;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int sync_lo(input int vis, input int fp);
      return vis + fp;
   endfunction

   function automatic int sync_hi(input int vis, input int fp, input int sync);
      return vis + fp + sync - 1;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus the stage-0 sync, visible and image flags.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP,
   parameter int IMG_W  = VGA_IMG_W,
   parameter int IMG_H  = VGA_IMG_H,
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
   localparam int HW      = cnt_w(H_TOTAL),
   localparam int VW      = cnt_w(V_TOTAL)
)(
   input  logic          clk,
   input  logic          rst_n,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output tmg_flags_t    flags
);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] HS_LO  = HW'(sync_lo(H_VIS, H_FP));
   localparam logic [HW-1:0] HS_HI  = HW'(sync_hi(H_VIS, H_FP, H_SYNC));
   localparam logic [VW-1:0] VS_LO  = VW'(sync_lo(V_VIS, V_FP));
   localparam logic [VW-1:0] VS_HI  = VW'(sync_hi(V_VIS, V_FP, V_SYNC));
   localparam logic [HW-1:0] H_VISC = HW'(H_VIS);
   localparam logic [VW-1:0] V_VISC = VW'(V_VIS);
   localparam logic [HW-1:0] H_IMGC = HW'(PIX_REP * IMG_W);
   localparam logic [VW-1:0] V_IMGC = VW'(PIX_REP * IMG_H);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      flags         = '0;
      flags.hsync   = ~((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
      flags.vsync   = ~((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
      flags.visible = (h_cnt < H_VISC) && (v_cnt < V_VISC);
      flags.image   = (h_cnt < H_IMGC) && (v_cnt < V_IMGC);
      flags.first   = (h_cnt == '0) && (v_cnt == '0);
   end

endmodule

// File: rtl/vga_buffer_reader.sv
// Scans a 2x-upscaled frame buffer out to VGA; outputs lag the raster counters by 2 clk.
module vga_buffer_reader
   import vga_pkg::*;
#(
   parameter int AW     = 17,
   parameter int DW     = 16,
   parameter int IMG_W  = VGA_IMG_W,
   parameter int IMG_H  = VGA_IMG_H,
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP
)(
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] addr_out,
   output logic          regread,
   input  logic [DW-1:0] data_in,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [DW-1:0] rgb,
   output logic          frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_w(H_TOTAL);
   localparam int VW      = cnt_w(V_TOTAL);

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_IMGC    = VW'(PIX_REP * IMG_H);
   localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);

   localparam tmg_flags_t TMG_IDLE = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};

   if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << AW)) begin : g_chk_aw
      $error("vga_buffer_reader: IMG_W*IMG_H does not fit in AW address bits");
   end
   if (PIX_REP * IMG_W > H_VIS) begin : g_chk_w
      $error("vga_buffer_reader: upscaled image wider than visible area");
   end
   if (PIX_REP * IMG_H > V_VIS) begin : g_chk_h
      $error("vga_buffer_reader: upscaled image taller than visible area");
   end

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   tmg_flags_t    flags;
   tmg_flags_t    tmg_q;
   logic          line_end;
   logic          frame_end;
   logic          img_row;
   logic [AW-1:0] line_base;
   logic [AW-1:0] offset;
   logic [AW-1:0] addr_cur;
   logic [AW-1:0] addr_q;

   vga_timing #(
      .H_VIS (H_VIS),
      .H_FP  (H_FP),
      .H_SYNC(H_SYNC),
      .H_BP  (H_BP),
      .V_VIS (V_VIS),
      .V_FP  (V_FP),
      .V_SYNC(V_SYNC),
      .V_BP  (V_BP),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_timing (
      .clk  (clk),
      .rst_n(rst_n),
      .h_cnt(h_cnt),
      .v_cnt(v_cnt),
      .flags(flags)
   );

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);
   assign img_row   = (v_cnt < V_IMGC);
   assign addr_cur  = line_base + offset;

   // The buffer registers its read, so the request must go out in the stage-0 cycle.
   assign regread  = flags.image & rst_n;
   assign addr_out = flags.image ? addr_cur : addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_base <= '0;
         offset    <= '0;
         addr_q    <= '0;
      end else begin
         if (flags.image) addr_q <= addr_cur;
         if (line_end) begin
            offset <= '0;
            if (frame_end)
               line_base <= '0;
            else if (img_row && v_cnt[0])
               line_base <= line_base + LINE_STEP;
         end else if (flags.image && h_cnt[0]) begin
            offset <= offset + 1'b1;
         end
      end
   end

   // Stage 1 holds the flags while the buffer returns data; stage 2 is the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmg_q       <= TMG_IDLE;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
      end else begin
         tmg_q       <= flags;
         hsync       <= tmg_q.hsync;
         vsync       <= tmg_q.vsync;
         de          <= tmg_q.visible;
         rgb         <= tmg_q.image ? data_in : '0;
         frame_start <= tmg_q.first;
      end
   end

endmodule

// File: tb/tb_vga_buffer_reader.sv
// Scoreboarded bench on a shrunken raster (58x37 total, 16x12 image) so whole frames run quickly.
module tb_vga_buffer_reader;

   localparam int AW = 8, DW = 16, IMG_W = 16, IMG_H = 12;
   localparam int H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 6;
   localparam int V_VIS = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int H_TOTAL = 58, V_TOTAL = 37;
   localparam int FRAME = H_TOTAL * V_TOTAL;
   localparam int NPIX = IMG_W * IMG_H;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] addr_out;
   logic          regread;
   logic [DW-1:0] data_in = '0;
   logic          hsync, vsync, de, frame_start;
   logic [DW-1:0] rgb;

   always #5 clk = ~clk;

   vga_buffer_reader #(
      .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H),
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr_out(addr_out), .regread(regread),
      .data_in(data_in), .hsync(hsync), .vsync(vsync), .de(de),
      .rgb(rgb), .frame_start(frame_start)
   );

   // Buffer model: 1-clk registered read, pixel value = address + 0x1000 so it never looks blank.
   always @(posedge clk) if (regread) data_in <= 16'h1000 + 16'(addr_out);

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic in_img(input int x, input int y);
      return (x < 2*IMG_W) && (y < 2*IMG_H);
   endfunction

   function automatic int pix_addr(input int x, input int y);
      return (y/2)*IMG_W + x/2;
   endfunction

   typedef struct {
      int          due;
      int          x, y;
      logic        hs, vs, de, fs;
      logic [15:0] rgb;
   } exp_t;

   exp_t sb[$];
   exp_t nx, cur;
   int   mh = 0, mv = 0, edge_n = 0;

   // Expected-response producer: tracks the raster independently and schedules each position's output.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mh = 0; mv = 0; edge_n = 0;
         sb.delete();
      end else begin
         edge_n++;
         nx.due = edge_n + 1;
         nx.x   = mh;
         nx.y   = mv;
         nx.hs  = !(mh >= H_VIS+H_FP && mh < H_VIS+H_FP+H_SYNC);
         nx.vs  = !(mv >= V_VIS+V_FP && mv < V_VIS+V_FP+V_SYNC);
         nx.de  = (mh < H_VIS) && (mv < V_VIS);
         nx.fs  = (mh == 0) && (mv == 0);
         nx.rgb = in_img(mh, mv) ? 16'(16'h1000 + pix_addr(mh, mv)) : 16'h0;
         sb.push_back(nx);
         if (mh == H_TOTAL-1) begin
            mh = 0;
            mv = (mv == V_TOTAL-1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
   end

   // Hand-computed pixels: (x, y) -> rgb.
   int spot_x [8] = '{0, 1, 2, 5, 31, 32, 0, 39};
   int spot_y [8] = '{0, 0, 0, 3, 23, 0, 24, 29};
   int spot_v [8] = '{'h1000, 'h1000, 'h1001, 'h1012, 'h10BF, 0, 0, 0};

   // Monitor: compares the request side every cycle and pops output expectations as they fall due.
   initial forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
         check("reset_outputs", 32'({hsync, vsync, de, frame_start, regread, rgb, addr_out}),
               32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0}));
      end else begin
         check("regread", 32'(regread), 32'(in_img(mh, mv)));
         if (in_img(mh, mv)) check("addr_out", 32'(addr_out), 32'(pix_addr(mh, mv)));
         while (sb.size() > 0 && sb[0].due <= edge_n) begin
            cur = sb.pop_front();
            check("hsync", 32'(hsync), 32'(cur.hs));
            check("vsync", 32'(vsync), 32'(cur.vs));
            check("de", 32'(de), 32'(cur.de));
            check("frame_start", 32'(frame_start), 32'(cur.fs));
            check("rgb", 32'(rgb), 32'(cur.rgb));
            for (int i = 0; i < 8; i++)
               if (spot_x[i] == cur.x && spot_y[i] == cur.y) check("spot_rgb", 32'(rgb), 32'(spot_v[i]));
         end
      end
   end

   int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$];
   logic hs_d, vs_d;
   int   de_cnt, rd_cnt, oob, bad_hist, found, lat_hs, lat_fs;
   int   hist [256];

   initial begin
      for (int i = 0; i < 256; i++) hist[i] = 0;
      de_cnt = 0; rd_cnt = 0; oob = 0; bad_hist = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Edge index e: output sampled after the e-th rising edge since release.
      hs_d = 1'b1; vs_d = 1'b1;
      for (int e = 0; e < 2*FRAME + 60; e++) begin
         #1;
         if (hs_d && !hsync) hs_fall.push_back(e);
         if (!hs_d && hsync) hs_rise.push_back(e);
         if (vs_d && !vsync) vs_fall.push_back(e);
         if (!vs_d && vsync) vs_rise.push_back(e);
         hs_d = hsync; vs_d = vsync;
         if (frame_start) fs_at.push_back(e);
         if (e >= 2 && e < FRAME + 2 && de) de_cnt++;
         if (e < FRAME && regread) begin
            rd_cnt++;
            if (int'(addr_out) >= NPIX) oob++;
            else hist[addr_out]++;
         end
         @(negedge clk);
      end

      check("hs_edges_seen", 32'(hs_fall.size() >= 2 && hs_rise.size() >= 1), 32'd1);
      if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
         check("hs_first_low", 32'(hs_fall[0]), 32'd46);
         check("hs_period", 32'(hs_fall[1] - hs_fall[0]), 32'd58);
         check("hs_low_len", 32'(hs_rise[0] - hs_fall[0]), 32'd8);
      end
      check("vs_edges_seen", 32'(vs_fall.size() >= 2 && vs_rise.size() >= 1), 32'd1);
      if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
         check("vs_first_low", 32'(vs_fall[0]), 32'd1858);
         check("vs_period", 32'(vs_fall[1] - vs_fall[0]), 32'd2146);
         check("vs_low_len", 32'(vs_rise[0] - vs_fall[0]), 32'd116);
      end
      check("fs_seen", 32'(fs_at.size() >= 2), 32'd1);
      if (fs_at.size() >= 2) begin
         check("fs_first", 32'(fs_at[0]), 32'd2);
         check("fs_period", 32'(fs_at[1] - fs_at[0]), 32'd2146);
      end
      check("de_per_frame", 32'(de_cnt), 32'd1200);
      check("reads_per_frame", 32'(rd_cnt), 32'd768);
      check("addr_out_of_range", 32'(oob), 32'd0);
      for (int a = 0; a < NPIX; a++) if (hist[a] != 4) bad_hist++;
      check("addr_not_read_4x", 32'(bad_hist), 32'd0);

      // Mid-frame reset at raster (20,15), asserted between clock edges.
      found = 0;
      for (int i = 0; i < 2*FRAME && found == 0; i++) begin
         @(negedge clk); #1;
         if (mh == 20 && mv == 15) found = 1;
      end
      check("reach_mid_frame", 32'(found), 32'd1);
      check("de_before_reset", 32'(de), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'({hsync, vsync, de, frame_start, regread, rgb, addr_out}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0}));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      lat_hs = -1; lat_fs = -1;
      for (int e = 0; e < 200 && lat_hs < 0; e++) begin
         #1;
         if (frame_start && lat_fs < 0) lat_fs = e;
         if (!hsync) lat_hs = e;
         @(negedge clk);
      end
      check("restart_fs_latency", 32'(lat_fs), 32'd2);
      check("restart_hs_latency", 32'(lat_hs), 32'd46);

      repeat (200) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
